clk_period_meas: RTL and testbench

CLK_PERIOD_MEAS -- requirements
Module: clk_period_meas

---
 rtl/clk_period_meas.sv | 148 ++++++++++++++
 tb/tb_clk_period_meas.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/clk_period_meas.sv
// Measures the period and high time of a slow asynchronous clock in system clock cycles.
// Optional duty-cycle flag output is enabled by defining CLK_PERIOD_MEAS_DUTY_EN.
module clk_period_meas #(
    parameter int MAX_PERIOD = 255,
    localparam int W = $clog2(MAX_PERIOD + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clk_in,
    input  logic         meas_ready,
    output logic         meas_valid,
    output logic [W-1:0] period,
    output logic [W-1:0] high_time,
    output logic         no_clk,
    output logic         overrun
`ifdef CLK_PERIOD_MEAS_DUTY_EN
    ,output logic        duty_ok
`endif
);

    typedef enum logic {
        IDLE,
        MEASURE
    } state_t;

    localparam logic [W-1:0] MAX_CNT = W'(MAX_PERIOD);
    localparam logic [W-1:0] ONE     = W'(1);

    state_t         r_state;
    logic           r_s1;
    logic           r_s2;
    logic           r_s3;
    logic [W-1:0]   r_pcnt;
    logic [W-1:0]   r_hcnt;
    logic [W-1:0]   r_period;
    logic [W-1:0]   r_high;
    logic           r_valid;
    logic           r_overrun;

    logic           w_rise;
    logic           w_offer;
    logic           w_accept;

    assign w_rise   = r_s2 & ~r_s3;
    assign w_offer  = (r_state == MEASURE) & w_rise;
    assign w_accept = ~r_valid | meas_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= clk_in;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    // The cycle carrying the rise counts as the first cycle of the new period.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_pcnt  <= '0;
            r_hcnt  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_rise) begin
                        r_state <= MEASURE;
                        r_pcnt  <= ONE;
                        r_hcnt  <= ONE;
                    end
                end
                MEASURE: begin
                    if (w_rise) begin
                        r_pcnt <= ONE;
                        r_hcnt <= ONE;
                    end else if (r_pcnt == MAX_CNT) begin
                        r_state <= IDLE;
                        r_pcnt  <= '0;
                        r_hcnt  <= '0;
                    end else begin
                        r_pcnt <= r_pcnt + ONE;
                        r_hcnt <= r_hcnt + {{(W-1){1'b0}}, r_s2};
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_pcnt  <= '0;
                    r_hcnt  <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid   <= 1'b0;
            r_period  <= '0;
            r_high    <= '0;
            r_overrun <= 1'b0;
        end else if (w_offer && w_accept) begin
            r_valid  <= 1'b1;
            r_period <= r_pcnt;
            r_high   <= r_hcnt;
        end else begin
            if (w_offer) begin
                r_overrun <= 1'b1;
            end
            if (r_valid && meas_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

`ifdef CLK_PERIOD_MEAS_DUTY_EN
    // Widened by one bit so doubling the high count cannot overflow.
    logic [W:0] w_two_high;
    logic [W:0] w_pwide;
    logic [W:0] w_diff;
    logic       w_duty;
    logic       r_duty;

    assign w_two_high = {r_hcnt, 1'b0};
    assign w_pwide    = {1'b0, r_pcnt};
    assign w_diff     = (w_two_high >= w_pwide) ? (w_two_high - w_pwide)
                                                : (w_pwide - w_two_high);
    assign w_duty     = (w_diff <= (W+1)'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_duty <= 1'b0;
        end else if (w_offer && w_accept) begin
            r_duty <= w_duty;
        end
    end

    assign duty_ok = r_duty;
`endif

    assign meas_valid = r_valid;
    assign period     = r_period;
    assign high_time  = r_high;
    assign no_clk     = (r_state == IDLE);
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_clk_period_meas.sv
// Directed self-checking bench for clk_period_meas with MAX_PERIOD = 15.
// Covers steady measurement, overrun, timeout, restart and mid-period reset.
module tb_clk_period_meas;

    localparam int MAXP = 15;
    localparam int W    = $clog2(MAXP + 1);

    logic         clk;
    logic         rst;
    logic         clk_in;
    logic         meas_ready;
    logic         meas_valid;
    logic [W-1:0] period;
    logic [W-1:0] high_time;
    logic         no_clk;
    logic         overrun;
`ifdef CLK_PERIOD_MEAS_DUTY_EN
    logic         duty_ok;
`endif

    int checks = 0;
    int errors = 0;

    int genHi = 1;
    int genLo = 1;
    bit genOn = 1'b0;
    int phase = 0;

    clk_period_meas #(.MAX_PERIOD(MAXP)) dut (
        .clk        (clk),
        .rst        (rst),
        .clk_in     (clk_in),
        .meas_ready (meas_ready),
        .meas_valid (meas_valid),
        .period     (period),
        .high_time  (high_time),
        .no_clk     (no_clk),
        .overrun    (overrun)
`ifdef CLK_PERIOD_MEAS_DUTY_EN
        ,.duty_ok   (duty_ok)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slow clock generator: high for genHi cycles then low for genLo, starting high when enabled.
    always @(posedge clk) begin
        #1;
        if (!genOn) begin
            clk_in = 1'b0;
            phase  = 0;
        end else begin
            clk_in = (phase < genHi);
            phase  = (phase + 1 >= genHi + genLo) ? 0 : phase + 1;
        end
    end

    typedef struct {
        int hi;
        int lo;
        int expPeriod;
        int expHigh;
        int expDuty;
    } vec_t;

    vec_t vecs[6];

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int hi, input int lo, input bit ready);
        genHi      = hi;
        genLo      = lo;
        meas_ready = ready;
        genOn      = 1'b1;
    endtask

    task automatic waitValid(input int budget, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!meas_valid && n < budget);
        if (!meas_valid) begin
            checkOutput("wait_valid_timeout", 0, 1);
        end
    endtask

    task automatic applyReset();
        @(negedge clk);
        genOn      = 1'b0;
        meas_ready = 1'b0;
        rst        = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("rst_valid", int'(meas_valid), 0);
        checkOutput("rst_period", int'(period), 0);
        checkOutput("rst_no_clk", int'(no_clk), 1);
        rst = 1'b0;
    endtask

    initial begin
        int n;
        int firstLow;
        int firstHighAgain;
        int sawValid;

        vecs[0] = '{3, 4, 7, 3, 1};
        vecs[1] = '{1, 7, 8, 1, 0};
        vecs[2] = '{2, 3, 5, 2, 1};
        vecs[3] = '{7, 8, 15, 7, 1};
        vecs[4] = '{4, 2, 6, 4, 0};
        vecs[5] = '{1, 1, 2, 1, 1};

        rst        = 1'b1;
        meas_ready = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("init_valid", int'(meas_valid), 0);
        checkOutput("init_high", int'(high_time), 0);
        checkOutput("init_overrun", int'(overrun), 0);
        checkOutput("init_no_clk", int'(no_clk), 1);
`ifdef CLK_PERIOD_MEAS_DUTY_EN
        checkOutput("init_duty", int'(duty_ok), 0);
`endif

        // Steady-state measurement table, consumer always ready.
        foreach (vecs[i]) begin
            applyReset();
            applyStimulus(vecs[i].hi, vecs[i].lo, 1'b1);
            waitValid(60, n);
            checkOutput($sformatf("v%0d_latency", i), n, vecs[i].expPeriod + 4);
            checkOutput($sformatf("v%0d_period", i), int'(period), vecs[i].expPeriod);
            checkOutput($sformatf("v%0d_high", i), int'(high_time), vecs[i].expHigh);
            checkOutput($sformatf("v%0d_no_clk", i), int'(no_clk), 0);
`ifdef CLK_PERIOD_MEAS_DUTY_EN
            checkOutput($sformatf("v%0d_duty", i), int'(duty_ok), vecs[i].expDuty);
`endif
            for (int k = 0; k < 2; k++) begin
                waitValid(40, n);
                checkOutput($sformatf("v%0d_interval%0d", i, k), n, vecs[i].expPeriod);
                checkOutput($sformatf("v%0d_period%0d", i, k), int'(period), vecs[i].expPeriod);
                checkOutput($sformatf("v%0d_high%0d", i, k), int'(high_time), vecs[i].expHigh);
            end
            checkOutput($sformatf("v%0d_overrun", i), int'(overrun), 0);
        end

        // Lock at period 15, then stop the slow clock: timeout lands 15 cycles after the last rise.
        applyReset();
        applyStimulus(7, 8, 1'b1);
        waitValid(60, n);
        checkOutput("stop_lock_period", int'(period), 15);
        genOn    = 1'b0;
        n        = 0;
        sawValid = 0;
        do begin
            @(negedge clk);
            n++;
            if (meas_valid) sawValid = 1;
        end while (!no_clk && n < 40);
        checkOutput("stop_timeout_cycle", n, 15);
        checkOutput("stop_no_new_valid", sawValid, 0);
        applyStimulus(7, 8, 1'b1);
        waitValid(60, n);
        checkOutput("restart_latency", n, 19);
        checkOutput("restart_period", int'(period), 15);

        // Period 16 never completes: one idle cycle between timeout and the re-arming rise.
        applyReset();
        applyStimulus(8, 8, 1'b1);
        firstLow       = 0;
        firstHighAgain = 0;
        sawValid       = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (meas_valid) sawValid = 1;
            if (firstLow == 0 && !no_clk) firstLow = c;
            if (firstLow != 0 && firstHighAgain == 0 && no_clk) firstHighAgain = c;
        end
        checkOutput("p16_arm_cycle", firstLow, 4);
        checkOutput("p16_timeout_cycle", firstHighAgain, 19);
        checkOutput("p16_no_valid", sawValid, 0);

        // Consumer stalled: held result survives later periods, overrun is sticky.
        applyReset();
        applyStimulus(2, 3, 1'b0);
        waitValid(60, n);
        checkOutput("ovr_first_period", int'(period), 5);
        checkOutput("ovr_first_high", int'(high_time), 2);
        checkOutput("ovr_first_flag", int'(overrun), 0);
        genHi = 1;
        genLo = 3;
        repeat (30) @(negedge clk);
        checkOutput("ovr_held_valid", int'(meas_valid), 1);
        checkOutput("ovr_held_period", int'(period), 5);
        checkOutput("ovr_held_high", int'(high_time), 2);
        checkOutput("ovr_flag", int'(overrun), 1);
        meas_ready = 1'b1;
        @(negedge clk);
        waitValid(40, n);
        checkOutput("ovr_new_period", int'(period), 4);
        checkOutput("ovr_new_high", int'(high_time), 1);
        checkOutput("ovr_sticky", int'(overrun), 1);

        // Single-cycle reset mid-period while a result is held.
        meas_ready = 1'b0;
        @(negedge clk);
        waitValid(40, n);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("mrst_valid", int'(meas_valid), 0);
        checkOutput("mrst_period", int'(period), 0);
        checkOutput("mrst_high", int'(high_time), 0);
        checkOutput("mrst_overrun", int'(overrun), 0);
        checkOutput("mrst_no_clk", int'(no_clk), 1);
        meas_ready = 1'b1;
        waitValid(40, n);
        checkOutput("mrst_next_period", int'(period), 4);
        checkOutput("mrst_next_high", int'(high_time), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
